riscv_mem_arbiter: RTL and testbench
====================================

Name: riscv_mem_arbiter

Overview:
- Arbitrates and sequences one shared synchronous on-chip memory between two requesters of the multicycle RISC-V core: the instruction-fetch path (MAR/IR) and the data path (data_mem_R/data_mem_W).
- Decodes one memory-mapped IO word: reads return the 10 board switches, writes drive the 10 LEDs.
- Sits between the control FSM (curr_state) and the memory macro.
- Exposes a req/ack handshake to each requester, so the control FSM stalls in its memory states until ack arrives.

Parameters:
- ADDR_W, 32, width of the address bus.
- DATA_W, 32, width of the data bus.
- MEM_LAT, 2, cycles from the mem_en cycle to the cycle in which mem_rdata is valid. Legal range is 1 to 7.
- IO_ADDR, 32'hFFFF_FFFC, data-port address that maps to the SW/LED word.

Ports:
- Clk  in  1  system clock.
- Reset_n  in  1  asynchronous active-low reset.
- if_req  in  1  fetch request; held high until if_ack.
- if_addr  in  ADDR_W  fetch address; held stable while if_req is high.
- if_rdata  out  DATA_W  fetched word; valid while if_ack is high.
- if_ack  out  1  one-cycle completion pulse for the fetch port.
- dm_req  in  1  data request; held high until dm_ack.
- dm_we  in  1  1 = write, 0 = read.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  write data.
- dm_rdata  out  DATA_W  read data; valid while dm_ack is high.
- dm_ack  out  1  one-cycle completion pulse for the data port.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- SW  in  10  board switches (asynchronous).
- LED  out  10  IO output register.
- busy  out  1  high in every state except IDLE.
- grant_dm  out  1  1 while the data port owns the transaction.

Behaviour:
- Reset (asynchronous, Reset_n low):
  - Registered outputs clear to 0: if_rdata, dm_rdata, if_ack, dm_ack, mem_en, mem_we, mem_addr, mem_wdata, LED, busy, grant_dm.
  - FSM goes to IDLE; the priority pointer is set to data-first.
  - SW synchronizer flops clear to 0.
- Reset mid-transaction: the transaction is abandoned; no ack is issued and no mem_we pulse follows the deassertion of reset.
- SW passes through a 2-flop synchronizer. IO reads return {22'b0, sw_sync}.
- FSM states: IDLE, ISSUE, WAIT, DONE. All outputs are registered (Moore).
- IDLE:
  - No request: stay in IDLE.
  - One request: grant it.
  - Both requests: grant the requester not served last. After reset, the data port wins the first conflict.
  - On a grant: latch the owner (grant_dm), address, we and wdata; go to ISSUE.
- ISSUE (one cycle):
  - Memory access: mem_en = 1 and mem_addr = the latched address. mem_we = 1 only for a data write.
  - Memory read: go to WAIT.
  - Memory write: go to DONE.
  - Data access with dm_addr == IO_ADDR: mem_en stays 0. A write loads LED <= wdata[9:0]; a read captures sw_sync. Go to DONE.
  - Fetch from IO_ADDR is an ordinary memory read (no IO decode on the fetch port).
- WAIT:
  - Counter runs for MEM_LAT cycles; mem_en = 0.
  - On the last WAIT cycle, mem_rdata is registered into the owner's rdata; then go to DONE.
- DONE (one cycle):
  - The owner's ack = 1 and its rdata holds the result.
  - The priority pointer toggles to the other port.
  - Go to IDLE.
- Latency, with req first high in IDLE at cycle 0:
  - Memory read: ack in cycle MEM_LAT+2 (cycle 4 at the default).
  - Write or IO access: ack in cycle 2.
  - At least one IDLE cycle separates consecutive transactions.
- The non-owner's rdata holds its previous value; its ack stays 0.
- Requester rules:
  - The requester must deassert req, or present a new request, in the cycle after ack. A req still high in IDLE is treated as a new request.
  - Dropping req before ack is illegal. The arbiter still completes the transaction and pulses ack.
- A request that arrives while busy waits in IDLE arbitration; requests are never lost or reordered within a port.
- When addresses collide, a data write completes before a later fetch of the same address.

Test Plan:
- Reset then single fetch: if_addr=0x10, memory word 0x00A00093, MEM_LAT=2 -> mem_en high in cycle 1 only; if_ack in cycle 4 with if_rdata=0x00A00093; dm_ack stays 0.
- Conflict: if_req and dm_req both rise in the same cycle after reset -> data granted first (grant_dm=1); fetch granted in the following IDLE; ack order is dm then if.
- Fairness: both ports requesting continuously for 6 transactions -> grants alternate dm, if, dm, if, dm, if; no port waits more than one transaction.
- IO path: dm write 0x0000_02AA to IO_ADDR -> LED=10'h2AA, mem_en never high, dm_ack in cycle 2. Then SW=10'h155 and a dm read of IO_ADDR -> dm_rdata=0x00000155.
- Data write then read back: write 0xDEADBEEF to 0x40 -> mem_we high for exactly 1 cycle, ack in cycle 2. Read 0x40 -> dm_rdata=0xDEADBEEF.
- Reset_n pulsed low during WAIT of a read -> outputs 0 immediately (asynchronously); no ack; a request re-issued after reset completes normally.

Source files
------------

// File: rtl/riscv_mem_arbiter_if.sv
// Bus bundle between the two core requesters (fetch, data) and the shared
// memory macro. The arbiter takes the slave view; the core/memory side takes master.
interface riscv_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Handshake: a requester raises *_req with address/data stable and holds it
  // until the matching one-cycle *_ack; *_rdata is valid while *_ack is high.
  // In the cycle after ack, req must drop or carry a new request.
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_ack;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_rdata, if_ack, dm_rdata, dm_ack, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_rdata, if_ack, dm_rdata, dm_ack, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/riscv_mem_arbiter.sv
// Shares one synchronous memory between the fetch and data paths of the
// multicycle core, with round-robin arbitration and one SW/LED IO word.
module riscv_mem_arbiter #(
  parameter int              ADDR_W  = 32,
  parameter int              DATA_W  = 32,
  parameter int              MEM_LAT = 2,
  parameter logic [ADDR_W-1:0] IO_ADDR = 32'hFFFF_FFFC
) (
  input  logic                Clk,
  input  logic                Reset_n,
  riscv_mem_arbiter_if.slave  bus,
  input  logic [9:0]          SW,
  output logic [9:0]          LED,
  output logic                busy,
  output logic                grant_dm,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t     state, state_n;
  logic       prio_dm;
  logic [2:0] cnt;
  logic       lat_we;
  logic       lat_io;
  logic [9:0] sw_meta, sw_sync;
  logic       grant;
  logic       pick_dm;
  logic       io_hit;

  assign dbg_state = state;
  assign io_hit    = pick_dm && (bus.dm_addr == IO_ADDR);

  always_comb begin
    grant   = 1'b0;
    state_n = state;
    // prio_dm names the port that wins a simultaneous request
    pick_dm = bus.dm_req && (!bus.if_req || prio_dm);
    case (state)
      IDLE:    if (bus.if_req || bus.dm_req) begin
                 grant   = 1'b1;
                 state_n = ISSUE;
               end
      ISSUE:   state_n = (lat_io || lat_we) ? DONE : WAIT;
      WAIT:    if (cnt == '0) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sw_meta       <= '0;
      sw_sync       <= '0;
      prio_dm       <= 1'b1;
      cnt           <= '0;
      lat_we        <= 1'b0;
      lat_io        <= 1'b0;
      grant_dm      <= 1'b0;
      busy          <= 1'b0;
      LED           <= '0;
      bus.if_rdata  <= '0;
      bus.dm_rdata  <= '0;
      bus.if_ack    <= 1'b0;
      bus.dm_ack    <= 1'b0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      sw_meta    <= SW;
      sw_sync    <= sw_meta;
      busy       <= (state_n != IDLE);
      bus.mem_en <= 1'b0;
      bus.mem_we <= 1'b0;
      bus.if_ack <= 1'b0;
      bus.dm_ack <= 1'b0;

      // Outputs are registered, so the ISSUE-cycle strobes are loaded on the grant edge
      if (grant) begin
        grant_dm     <= pick_dm;
        lat_io       <= io_hit;
        lat_we       <= pick_dm && bus.dm_we;
        bus.mem_addr <= pick_dm ? bus.dm_addr : bus.if_addr;
        if (pick_dm) bus.mem_wdata <= bus.dm_wdata;
        bus.mem_en   <= !io_hit;
        bus.mem_we   <= pick_dm && bus.dm_we && !io_hit;
      end

      if (state == ISSUE) begin
        cnt <= 3'(MEM_LAT - 1);
        if (lat_io) begin
          if (lat_we) LED <= bus.mem_wdata[9:0];
          else        bus.dm_rdata <= DATA_W'(sw_sync);
        end
      end

      if (state == WAIT) begin
        if (cnt == '0) begin
          if (grant_dm) bus.dm_rdata <= bus.mem_rdata;
          else          bus.if_rdata <= bus.mem_rdata;
        end else begin
          cnt <= cnt - 3'd1;
        end
      end

      if (state_n == DONE) begin
        bus.dm_ack <= grant_dm;
        bus.if_ack <= !grant_dm;
      end

      if (state == DONE) prio_dm <= !grant_dm;
    end
  end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Directed bench for riscv_mem_arbiter: single fetch, data write/readback,
// IO word, reset during WAIT, and conflict/fairness between the two ports.
module tb_riscv_mem_arbiter;
  localparam int          ADDR_W  = 32;
  localparam int          DATA_W  = 32;
  localparam logic [31:0] IO_ADDR = 32'hFFFF_FFFC;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  riscv_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
  logic [9:0] sw;
  logic [9:0] led;
  logic       busy;
  logic       grant_dm;
  logic [1:0] dbg_state;

  riscv_mem_arbiter dut (
    .Clk       (clk),
    .Reset_n   (rst_n),
    .bus       (bus.slave),
    .SW        (sw),
    .LED       (led),
    .busy      (busy),
    .grant_dm  (grant_dm),
    .dbg_state (dbg_state)
  );

  // Memory model: read data valid exactly MEM_LAT(=2) cycles after the mem_en cycle
  logic [31:0] mem_arr [0:255];
  logic        v1 = 1'b0, v2 = 1'b0;
  logic [31:0] d1 = '0, d2 = '0;
  always @(posedge clk) begin
    v1 <= bus.mem_en && !bus.mem_we;
    d1 <= mem_arr[bus.mem_addr[9:2]];
    v2 <= v1;
    d2 <= d1;
    if (bus.mem_en && bus.mem_we) mem_arr[bus.mem_addr[9:2]] <= bus.mem_wdata;
  end
  assign bus.mem_rdata = v2 ? d2 : 32'hBAD0_BAD0;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Activity counters sampled mid-cycle
  int en_cnt = 0, we_cnt = 0, if_ack_cnt = 0, dm_ack_cnt = 0;
  always @(negedge clk) begin
    if (bus.mem_en) en_cnt++;
    if (bus.mem_we) we_cnt++;
    if (bus.if_ack) if_ack_cnt++;
    if (bus.dm_ack) dm_ack_cnt++;
  end

  task automatic clear_counts();
    en_cnt = 0; we_cnt = 0; if_ack_cnt = 0; dm_ack_cnt = 0;
  endtask

  // ---------------- driver tasks ----------------
  logic [31:0] en_mask;

  task automatic fetch(input logic [31:0] addr, input bit hold,
                       output logic [31:0] rdata, output int lat);
    @(posedge clk); #1;
    bus.if_req  = 1'b1;
    bus.if_addr = addr;
    lat     = -1;
    rdata   = '0;
    en_mask = '0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.mem_en && c < 32) en_mask[c] = 1'b1;
      if (bus.if_ack) begin
        lat   = c;
        rdata = bus.if_rdata;
        break;
      end
      @(posedge clk); #1;
    end
    if (lat < 0) check("fetch_timeout", 32'd0, 32'd1);
    if (!hold) begin
      @(posedge clk); #1;
      bus.if_req = 1'b0;
    end
  endtask

  task automatic dm_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input bit hold, output logic [31:0] rdata, output int lat);
    @(posedge clk); #1;
    bus.dm_req   = 1'b1;
    bus.dm_we    = we;
    bus.dm_addr  = addr;
    bus.dm_wdata = wdata;
    lat   = -1;
    rdata = '0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.dm_ack) begin
        lat   = c;
        rdata = bus.dm_rdata;
        break;
      end
      @(posedge clk); #1;
    end
    if (lat < 0) check("dm_timeout", 32'd0, 32'd1);
    if (!hold) begin
      @(posedge clk); #1;
      bus.dm_req = 1'b0;
      bus.dm_we  = 1'b0;
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [DATA_W-1:0] exp_q[$];
  bit                exp_dm_q[$];
  bit                sb_en = 1'b0;

  always @(negedge clk) begin
    if (sb_en && (bus.if_ack || bus.dm_ack)) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_ack", 32'd1, 32'd0);
      end else begin
        logic [31:0] d;
        bit          own;
        d   = exp_q.pop_front();
        own = exp_dm_q.pop_front();
        check("sb_owner_dm_ack", 32'(bus.dm_ack), 32'(own));
        check("sb_grant_dm", 32'(grant_dm), 32'(own));
        check("sb_rdata", own ? bus.dm_rdata : bus.if_rdata, d);
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [31:0] rd;
  int          lat;

  initial begin
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;
    sw = '0;
    for (int i = 0; i < 256; i++) mem_arr[i] = 32'h1000_0000 + 32'(i);
    mem_arr[4] = 32'h00A0_0093;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_if_ack", 32'(bus.if_ack), 32'd0);
    check("rst_dm_ack", 32'(bus.dm_ack), 32'd0);
    check("rst_mem_en", 32'(bus.mem_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    check("rst_led", 32'(led), 32'd0);
    rst_n = 1'b1;

    // Single fetch
    clear_counts();
    fetch(32'h10, 1'b0, rd, lat);
    check("fetch_lat", 32'(lat), 32'd4);
    check("fetch_rdata", rd, 32'h00A0_0093);
    check("fetch_en_cycle1", en_mask, 32'h0000_0002);
    check("fetch_no_dm_ack", 32'(dm_ack_cnt), 32'd0);

    // Data write then readback
    clear_counts();
    dm_txn(1'b1, 32'h40, 32'hDEAD_BEEF, 1'b0, rd, lat);
    check("wr_lat", 32'(lat), 32'd2);
    check("wr_we_pulses", 32'(we_cnt), 32'd1);
    dm_txn(1'b0, 32'h40, 32'h0, 1'b0, rd, lat);
    check("rd_lat", 32'(lat), 32'd4);
    check("rd_rdata", rd, 32'hDEAD_BEEF);

    // IO word
    clear_counts();
    dm_txn(1'b1, IO_ADDR, 32'h0000_02AA, 1'b0, rd, lat);
    check("io_wr_lat", 32'(lat), 32'd2);
    check("io_led", 32'(led), 32'h2AA);
    sw = 10'h155;
    repeat (3) @(posedge clk);
    dm_txn(1'b0, IO_ADDR, 32'h0, 1'b0, rd, lat);
    check("io_rd_lat", 32'(lat), 32'd2);
    check("io_rd_sw", rd, 32'h0000_0155);
    check("io_no_mem_en", 32'(en_cnt), 32'd0);

    // Reset during the WAIT of a fetch
    @(posedge clk); #1;
    bus.if_req = 1'b1; bus.if_addr = 32'h10;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_state", 32'(dbg_state), 32'd0);
    check("arst_mem_addr", bus.mem_addr, 32'd0);
    check("arst_if_rdata", bus.if_rdata, 32'd0);
    check("arst_dm_rdata", bus.dm_rdata, 32'd0);
    check("arst_led", 32'(led), 32'd0);
    bus.if_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    clear_counts();
    repeat (10) @(posedge clk);
    #1;
    check("arst_no_ack", 32'(if_ack_cnt + dm_ack_cnt), 32'd0);
    check("arst_no_we", 32'(we_cnt), 32'd0);
    fetch(32'h10, 1'b0, rd, lat);
    check("arst_refetch_lat", 32'(lat), 32'd4);
    check("arst_refetch_rdata", rd, 32'h00A0_0093);

    // Conflict and fairness, from a fresh reset so data wins first
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    exp_q    = '{32'h1000_0020, 32'h1000_0008, 32'h1000_0021,
                 32'h1000_0009, 32'h1000_0022, 32'h1000_000A};
    exp_dm_q = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    sb_en = 1'b1;
    fork
      begin
        logic [31:0] r;
        int          l;
        dm_txn(1'b0, 32'h80, 32'h0, 1'b1, r, l);
        dm_txn(1'b0, 32'h84, 32'h0, 1'b1, r, l);
        dm_txn(1'b0, 32'h88, 32'h0, 1'b0, r, l);
      end
      begin
        logic [31:0] r;
        int          l;
        fetch(32'h20, 1'b1, r, l);
        fetch(32'h24, 1'b1, r, l);
        fetch(32'h28, 1'b0, r, l);
      end
    join
    repeat (2) @(posedge clk);
    sb_en = 1'b0;
    check("fair_all_acked", 32'(exp_q.size()), 32'd0);

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_errors);
    $fatal(1, "watchdog");
  end

endmodule
